mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a load/store requester.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     state;
    logic [2:0] cnt;
    logic       sel_d;
    logic       lat_we;
    logic       grant_d;
`ifdef MEM_ARB_RR_EN
    logic last_d;
    always_ff @(posedge clock or posedge rst)
        if (rst) last_d <= 1'b1;
        else if (state == IDLE && (f_req || d_req)) last_d <= grant_d;
    assign grant_d = d_req && !(f_req && last_d);
`else
    assign grant_d = d_req;
`endif
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_d     <= 1'b0;
            lat_we    <= 1'b0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: if (f_req || d_req) begin
                    // mem_* registers double as the latched request during ISSUE
                    sel_d     <= grant_d;
                    lat_we    <= grant_d && d_we;
                    mem_en    <= 1'b1;
                    mem_we    <= grant_d && d_we;
                    mem_addr  <= grant_d ? d_addr : f_addr;
                    mem_wdata <= grant_d ? d_wdata : '0;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: if (cnt == 3'(MEM_LAT - 1)) begin
                    if (!lat_we) rdata <= mem_rdata;
                    f_ack <= !sel_d;
                    d_ack <= sel_d;
                    state <= RESP;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_mem_port_arbiter;
    localparam int L1 = 1;
    localparam int L3 = 3;
    typedef struct packed {logic is_d; logic [15:0] rd;} ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic        f_ack, d_ack, mem_en, mem_we, busy;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        f_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
    logic [15:0] f_addr3 = '0, d_addr3 = '0, d_wdata3 = '0;
    logic        f_ack3, d_ack3, mem_en3, mem_we3, busy3;
    logic [15:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L1)) dut (
        .clock(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L3)) dut3 (
        .clock(clk), .rst(rst), .f_req(f_req3), .f_addr(f_addr3), .f_ack(f_ack3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_ack(d_ack3),
        .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3));

    // memory models: read data is only valid in the single cycle MEM_LAT after mem_en
    logic [15:0] mem [0:255];
    logic [7:0]  ma;
    int          k = 0, k3 = 0;
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h04] <= 16'h13b0;
            mem[8'h20] <= 16'habcd;
        end else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en) ma <= mem_addr[7:0];
        k  <= rst ? 0 : mem_en ? 1 : (k != 0) ? k + 1 : 0;
        k3 <= rst ? 0 : mem_en3 ? 1 : (k3 != 0) ? k3 + 1 : 0;
    end
    assign mem_rdata  = (k == L1) ? mem[ma] : 16'hdead;
    assign mem_rdata3 = (k3 == L3) ? 16'h5a5a : 16'hdead;

    int          total = 0, bad = 0;
    ent_t        sb [$];
    ent_t        e;
    logic [15:0] mdl [0:255];
    logic [15:0] exp_rd = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (f_ack || d_ack)) begin
            if (sb.size() == 0) chk("unexp_ack", {f_ack, d_ack}, 0);
            else begin
                e = sb.pop_front();
                chk("ack_port", {f_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
                chk("rdata", rdata, e.rd);
            end
        end
    end

    // single access on the MEM_LAT=1 instance with full latency and memory-side checks
    task automatic run1(input logic is_d, input logic we, input logic [15:0] a, input logic [15:0] wd);
        int en_at = -1, ack_at = -1;
        logic [15:0] rd;
        rd = we ? exp_rd : mdl[a[7:0]];
        sb.push_back({is_d, rd});
        if (we) mdl[a[7:0]] = wd; else exp_rd = rd;
        if (is_d) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
        else begin f_req = 1'b1; f_addr = a; end
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            @(negedge clk);
            if (mem_en) begin
                en_at = i;
                chk("mem_addr", mem_addr, a);
                chk("mem_we", mem_we, we);
                chk("mem_wdata", mem_wdata, is_d ? wd : 16'h0);
            end
            if (i == 2) chk("mem_idle", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
            if (f_ack || d_ack) ack_at = i;
            if (i == 1) begin f_addr = ~a; d_addr = ~a; d_wdata = ~wd; end
        end
        chk("en_lat", en_at, 1);
        chk("ack_lat", ack_at, L1 + 2);
        @(posedge clk); #1;
        f_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic req_one(input logic is_d, input logic [15:0] a);
        int n = 0;
        logic got = 1'b0;
        if (is_d) begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
        else begin f_req = 1'b1; f_addr = a; end
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = is_d ? d_ack : f_ack;
        end
        if (!got) chk("req_timeout", 0, 1);
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0; else f_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int ack_at, bcnt;
        mdl[8'h04] = 16'h13b0;
        mdl[8'h20] = 16'habcd;
        repeat (3) @(negedge clk);
        chk("rst_out1", {busy, mem_en, mem_we, f_ack, d_ack, rdata, mem_addr, mem_wdata}, 0);
        chk("rst_out3", {busy3, mem_en3, f_ack3, d_ack3, rdata3}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run1(1'b0, 1'b0, 16'h0004, 16'h0000);
        run1(1'b1, 1'b1, 16'h0010, 16'h1234);
        run1(1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int r = 0; r < 2; r++) begin
`ifdef MEM_ARB_RR_EN
            sb.push_back({1'b0, 16'h13b0});
            sb.push_back({1'b1, 16'h1234});
            exp_rd = 16'h1234;
`else
            sb.push_back({1'b1, 16'h1234});
            sb.push_back({1'b0, 16'h13b0});
            exp_rd = 16'h13b0;
`endif
            fork
                req_one(1'b0, 16'h0004);
                req_one(1'b1, 16'h0010);
            join
        end
        chk("contend_drain", sb.size(), 0);
        // abort a load in WAIT with an asynchronous reset
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0004;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #1 rst = 1'b1;
        #1 chk("rst_async", {busy, mem_en, mem_we, f_ack, d_ack, rdata, mem_addr, mem_wdata}, 0);
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_rd = '0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {busy, f_ack, d_ack}, 0);
        @(posedge clk); #1;
        run1(1'b0, 1'b0, 16'h0020, 16'h0000);
        // latency sweep on the MEM_LAT=3 instance
        ack_at = -1;
        bcnt = 0;
        d_req3 = 1'b1; d_addr3 = 16'h0008;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy3) bcnt++;
            if (i == 1) chk("l3_mem_en", {mem_en3, mem_addr3}, {1'b1, 16'h0008});
            if (d_ack3) begin
                ack_at = i;
                chk("l3_rdata", rdata3, 16'h5a5a);
            end
            if (f_ack3) chk("l3_f_ack", f_ack3, 0);
            if (d_ack3) begin @(posedge clk); #1 d_req3 = 1'b0; end
        end
        chk("l3_ack_lat", ack_at, L3 + 2);
        chk("l3_busy_cycles", bcnt, L3 + 2);
        chk("l3_rdata_hold", rdata3, 16'h5a5a);
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
